// File: rtl/pwr_seq_multi.sv
// pwr_seq_multi: N-channel power-rail sequencer.
// Brings rails up in ascending order, each after its own delay, and waits
// for that rail's power-good (PG) within a timeout before moving on. Once all
// rails are good, it holds the board reset for a while and then releases it.
// When the request is withdrawn, rails are dropped in reverse order. A PG
// timeout latches a fault, and the fault stays latched until it is cleared
// while power is not requested.
// Optional build macro: PWRSEQ_PG_MONITOR_EN. When it is defined, any rail
// that loses PG during RST_HOLD or ON forces the FAULT state.
module pwr_seq_multi #(
  parameter int unsigned         C_CLK_FREQ    = 100_000,
  parameter int unsigned         N_CH          = 4,
  parameter logic [N_CH*8-1:0]   C_UP_DLY_MS   = {N_CH{8'd10}},
  parameter int unsigned         C_PG_TO_MS    = 50,
  parameter int unsigned         C_RST_HOLD_MS = 5,
  parameter int unsigned         C_DN_DLY_MS   = 2,
  localparam int unsigned        CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pwr_req,
  input  logic [N_CH-1:0] pg,
  input  logic            fault_clr,
  output logic [N_CH-1:0] en_out,
  output logic            board_rst_n,
  output logic            power_ok,
  output logic            fault,
  output logic [CH_W-1:0] fault_ch
);

  localparam int unsigned      MS_W      = 8;
  localparam int unsigned      MS_MAX    = (1 << MS_W) - 1;
  localparam int unsigned      PS_W      = (C_CLK_FREQ > 1) ? $clog2(C_CLK_FREQ) : 1;
  localparam logic [PS_W-1:0]  PRESC_MAX = PS_W'(C_CLK_FREQ - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

  // Parameter sanity: every delay has to fit the 8-bit millisecond counter.
  if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
    $error("pwr_seq_multi: N_CH must be 1..16");
  end
  if (C_CLK_FREQ < 1) begin : g_chk_freq
    $error("pwr_seq_multi: C_CLK_FREQ must be at least 1");
  end
  if (C_PG_TO_MS < 1 || C_PG_TO_MS > MS_MAX) begin : g_chk_pg_to
    $error("pwr_seq_multi: C_PG_TO_MS must be 1..255");
  end
  if (C_RST_HOLD_MS > MS_MAX) begin : g_chk_rst_hold
    $error("pwr_seq_multi: C_RST_HOLD_MS exceeds ms counter range");
  end
  if (C_DN_DLY_MS > MS_MAX) begin : g_chk_dn_dly
    $error("pwr_seq_multi: C_DN_DLY_MS exceeds ms counter range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_UP_DLY, S_UP_PG, S_RST_HOLD, S_ON, S_DOWN, S_FAULT
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  ch;
  logic [PS_W-1:0]  presc;
  logic [MS_W-1:0]  ms_cnt;
  logic [N_CH-1:0]  pg_meta;
  logic [N_CH-1:0]  pg_sync;
  logic [N_CH-1:0]  ch_bit;
  logic [7:0]       up_dly [N_CH];
  logic [7:0]       up_sel;
  logic [7:0]       cur_dly;
  logic             expired;
  logic             pg_cur;

  // Unpack the per-rail power-up delays and decode the current channel.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    if (int'(C_UP_DLY_MS[gi*8 +: 8]) > MS_MAX) begin : g_chk_byte
      $error("pwr_seq_multi: C_UP_DLY_MS byte exceeds ms counter range");
    end
    assign up_dly[gi] = C_UP_DLY_MS[gi*8 +: 8];
    assign ch_bit[gi] = (ch == CH_W'(gi));
  end

  assign pg_cur = |(pg_sync & ch_bit);

  // Select the power-up delay of the current channel.
  always_comb begin
    up_sel = 8'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch == CH_W'(i)) up_sel = up_dly[i];
    end
  end

  // Select the delay for the current timed state. A delay of 0 still takes one clock.
  always_comb begin
    case (state)
      S_UP_DLY:   cur_dly = up_sel;
      S_UP_PG:    cur_dly = 8'(C_PG_TO_MS);
      S_RST_HOLD: cur_dly = 8'(C_RST_HOLD_MS);
      S_DOWN:     cur_dly = 8'(C_DN_DLY_MS);
      default:    cur_dly = 8'd0;
    endcase
    expired = (cur_dly == 8'd0) ||
              ((presc == PRESC_MAX) && (ms_cnt == cur_dly - 8'd1));
  end

`ifdef PWRSEQ_PG_MONITOR_EN
  logic [N_CH-1:0] mon_bad;
  logic            mon_any;
  logic [CH_W-1:0] mon_idx;

  assign mon_bad = en_out & ~pg_sync;
  assign mon_any = |mon_bad;

  // Report the lowest enabled rail that has lost its power-good.
  always_comb begin
    mon_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mon_bad[i]) mon_idx = CH_W'(i);
    end
  end
`endif

  // Two-flop synchroniser for the asynchronous PG inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pg_meta <= '0;
      pg_sync <= '0;
    end else begin
      pg_meta <= pg;
      pg_sync <= pg_meta;
    end
  end

  // Sequencer FSM with its ms timer. Any state or channel change restarts the timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ch          <= '0;
      presc       <= '0;
      ms_cnt      <= '0;
      en_out      <= '0;
      board_rst_n <= 1'b0;
      power_ok    <= 1'b0;
      fault       <= 1'b0;
      fault_ch    <= '0;
    end else begin
      if (presc == PRESC_MAX) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 8'd1;
      end else begin
        presc <= presc + PS_W'(1);
      end

      case (state)
        S_IDLE: begin
          en_out      <= '0;
          board_rst_n <= 1'b0;
          power_ok    <= 1'b0;
          if (pwr_req && !fault) begin
            state  <= S_UP_DLY;
            ch     <= '0;
            presc  <= '0;
            ms_cnt <= '0;
          end
        end

        S_UP_DLY: begin
          if (!pwr_req) begin
            // Only the lower ranks are on. Rail ch itself has not been enabled yet.
            if (ch == '0) begin
              state <= S_IDLE;
            end else begin
              state <= S_DOWN;
              ch    <= ch - CH_W'(1);
            end
            presc  <= '0;
            ms_cnt <= '0;
          end else if (expired) begin
            en_out <= en_out | ch_bit;
            state  <= S_UP_PG;
            presc  <= '0;
            ms_cnt <= '0;
          end
        end

        S_UP_PG: begin
          if (!pwr_req) begin
            state  <= S_DOWN;
            presc  <= '0;
            ms_cnt <= '0;
          end else if (pg_cur) begin
            if (ch == LAST_CH) begin
              state <= S_RST_HOLD;
            end else begin
              state <= S_UP_DLY;
              ch    <= ch + CH_W'(1);
            end
            presc  <= '0;
            ms_cnt <= '0;
          end else if (expired) begin
            state       <= S_FAULT;
            en_out      <= '0;
            board_rst_n <= 1'b0;
            power_ok    <= 1'b0;
            fault       <= 1'b1;
            fault_ch    <= ch;
            presc       <= '0;
            ms_cnt      <= '0;
          end
        end

        S_RST_HOLD: begin
`ifdef PWRSEQ_PG_MONITOR_EN
          if (mon_any) begin
            state       <= S_FAULT;
            en_out      <= '0;
            board_rst_n <= 1'b0;
            power_ok    <= 1'b0;
            fault       <= 1'b1;
            fault_ch    <= mon_idx;
            presc       <= '0;
            ms_cnt      <= '0;
          end else
`endif
          if (!pwr_req) begin
            state  <= S_DOWN;
            presc  <= '0;
            ms_cnt <= '0;
          end else if (expired) begin
            board_rst_n <= 1'b1;
            power_ok    <= 1'b1;
            state       <= S_ON;
            presc       <= '0;
            ms_cnt      <= '0;
          end
        end

        S_ON: begin
`ifdef PWRSEQ_PG_MONITOR_EN
          if (mon_any) begin
            state       <= S_FAULT;
            en_out      <= '0;
            board_rst_n <= 1'b0;
            power_ok    <= 1'b0;
            fault       <= 1'b1;
            fault_ch    <= mon_idx;
            presc       <= '0;
            ms_cnt      <= '0;
          end else
`endif
          if (!pwr_req) begin
            board_rst_n <= 1'b0;
            power_ok    <= 1'b0;
            state       <= S_DOWN;
            ch          <= LAST_CH;
            presc       <= '0;
            ms_cnt      <= '0;
          end
        end

        S_DOWN: begin
          // A new request is ignored here. It is honoured once IDLE is reached.
          if (expired) begin
            en_out <= en_out & ~ch_bit;
            if (ch == '0) begin
              state <= S_IDLE;
            end else begin
              ch <= ch - CH_W'(1);
            end
            presc  <= '0;
            ms_cnt <= '0;
          end
        end

        S_FAULT: begin
          en_out      <= '0;
          board_rst_n <= 1'b0;
          power_ok    <= 1'b0;
          if (fault_clr && !pwr_req) begin
            fault    <= 1'b0;
            fault_ch <= '0;
            state    <= S_IDLE;
            presc    <= '0;
            ms_cnt   <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_seq_multi.sv
// Bench for pwr_seq_multi using a 3-rail, 10-clocks-per-ms configuration.
// Scenario times are counted in clocks from UP_DLY entry, which is the first edge after pwr_req rises.
module tb_pwr_seq_multi;

  localparam int          F        = 10;
  localparam logic [23:0] UP       = 24'h030201;
  localparam int          PG_TO    = 4;
  localparam int          RST_HOLD = 5;
  localparam int          DN       = 2;
  localparam int          BUDGET   = 400;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pwr_req = 1'b0;
  logic       fault_clr = 1'b0;
  logic [2:0] pg = '0;
  logic [2:0] en_out;
  logic       board_rst_n;
  logic       power_ok;
  logic       fault;
  logic [1:0] fault_ch;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  pwr_seq_multi #(
    .C_CLK_FREQ(F), .N_CH(3), .C_UP_DLY_MS(UP), .C_PG_TO_MS(PG_TO),
    .C_RST_HOLD_MS(RST_HOLD), .C_DN_DLY_MS(DN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pwr_req(pwr_req), .pg(pg),
    .fault_clr(fault_clr), .en_out(en_out), .board_rst_n(board_rst_n),
    .power_ok(power_ok), .fault(fault), .fault_ch(fault_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    int         d0, d1, d2;
    logic [2:0] nv;
    int         e_en0, e_en1, e_en2, e_ok, e_flt, e_fch;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference timing from the sequencing rules: delay*F per timed wait, 3 clocks of PG latency plus the bench PG delay.
  task automatic model(input int d0, d1, d2, input logic [2:0] nv,
                       output int e_en0, e_en1, e_en2, e_ok, e_flt, e_fch);
    int d[3];
    int te[3];
    int t;
    bit stop;
    logic [23:0] u;
    u = UP;
    d[0] = d0; d[1] = d1; d[2] = d2;
    te = '{-1, -1, -1};
    e_ok = -1; e_flt = -1; e_fch = 0; stop = 0;
    t = int'(u[7:0]) * F;
    for (int i = 0; i < 3 && !stop; i++) begin
      te[i] = t;
      if (nv[i]) begin
        e_flt = t + PG_TO * F;
        e_fch = i;
        stop = 1;
      end else begin
        t = t + 3 + d[i];
        if (i == 2) e_ok = t + RST_HOLD * F;
        else t = t + int'(u[(i+1)*8 +: 8]) * F;
      end
    end
    e_en0 = te[0]; e_en1 = te[1]; e_en2 = te[2];
  endtask

  // Request power and answer each enabled rail with PG d clocks later, or never if the nv bit is set.
  task automatic run_scn(input int d0, d1, d2, input logic [2:0] nv,
                         output int r_en0, r_en1, r_en2, r_ok, r_flt, r_fch,
                         output int r_rst, output int r_enf);
    int d[3];
    int cnt[3];
    int te[3];
    int s;
    bit done;
    d[0] = d0; d[1] = d1; d[2] = d2;
    cnt = '{0, 0, 0};
    te = '{-1, -1, -1};
    r_ok = -1; r_flt = -1; r_fch = -1; r_rst = -1; r_enf = -1;
    pwr_req = 1'b1;
    s = cyc + 1;
    done = 0;
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (en_out[i]) begin
          if (te[i] < 0) te[i] = cyc - s;
          if (!nv[i] && cnt[i] >= d[i]) pg[i] = 1'b1;
          cnt[i]++;
        end else begin
          cnt[i] = 0;
          pg[i] = 1'b0;
        end
      end
      if (power_ok && r_ok < 0) begin
        r_ok = cyc - s; r_rst = int'(board_rst_n); done = 1;
      end
      if (fault && r_flt < 0) begin
        r_flt = cyc - s; r_fch = int'(fault_ch); r_enf = int'(en_out); done = 1;
      end
    end
    r_en0 = te[0]; r_en1 = te[1]; r_en2 = te[2];
  endtask

  // Withdraw the request from ON and time the reverse-order shutdown.
  task automatic power_down(input string tag);
    int c0, t011, t001, t000;
    t011 = -1; t001 = -1; t000 = -1;
    pwr_req = 1'b0;
    c0 = cyc;
    @(negedge clk);
    chk({tag, "_dn_rst"}, int'(board_rst_n), 0);
    chk({tag, "_dn_ok"}, int'(power_ok), 0);
    for (int k = 0; k < 100 && t000 < 0; k++) begin
      @(negedge clk);
      pg = pg & en_out;
      if (en_out == 3'b011 && t011 < 0) t011 = cyc - c0;
      if (en_out == 3'b001 && t001 < 0) t001 = cyc - c0;
      if (en_out == 3'b000 && t000 < 0) t000 = cyc - c0;
    end
    chk({tag, "_dn_en2"}, t011, 1 + DN * F);
    chk({tag, "_dn_en1"}, t001, 1 + 2 * DN * F);
    chk({tag, "_dn_en0"}, t000, 1 + 3 * DN * F);
    pg = '0;
    $display("down %s: en2_off=%0d en1_off=%0d en0_off=%0d", tag, t011, t001, t000);
  endtask

  // fault_clr is only honoured together with pwr_req=0.
  task automatic clear_fault(input string tag, input int exp_ch);
    pg = '0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    @(negedge clk);
    chk({tag, "_clr_req1_fault"}, int'(fault), 1);
    chk({tag, "_clr_req1_ch"}, int'(fault_ch), exp_ch);
    pwr_req = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_req0_fault_hold"}, int'(fault), 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk({tag, "_clr_fault"}, int'(fault), 0);
    chk({tag, "_clr_ch"}, int'(fault_ch), 0);
    chk({tag, "_clr_en"}, int'(en_out), 0);
    $display("clear %s: fault=%0d fault_ch=%0d", tag, fault, fault_ch);
    @(negedge clk);
  endtask

  task automatic do_scn(input string tag, input int d0, d1, d2, input logic [2:0] nv,
                        input int e_en0, e_en1, e_en2, e_ok, e_flt, e_fch);
    int r_en0, r_en1, r_en2, r_ok, r_flt, r_fch, r_rst, r_enf;
    run_scn(d0, d1, d2, nv, r_en0, r_en1, r_en2, r_ok, r_flt, r_fch, r_rst, r_enf);
    $display("scn %s: d=%0d/%0d/%0d nv=%b en=%0d/%0d/%0d ok=%0d flt=%0d ch=%0d",
             tag, d0, d1, d2, nv, r_en0, r_en1, r_en2, r_ok, r_flt, r_fch);
    chk({tag, "_en0"}, r_en0, e_en0);
    chk({tag, "_en1"}, r_en1, e_en1);
    chk({tag, "_en2"}, r_en2, e_en2);
    chk({tag, "_ok"}, r_ok, e_ok);
    chk({tag, "_flt"}, r_flt, e_flt);
    if (e_flt >= 0) begin
      chk({tag, "_fch"}, r_fch, e_fch);
      chk({tag, "_en_at_flt"}, r_enf, 0);
    end
    if (e_ok >= 0) chk({tag, "_rst_at_ok"}, r_rst, 1);
    if (r_flt >= 0) clear_fault(tag, e_fch);
    else power_down(tag);
  endtask

  initial begin : main
    vec_t vecs [6];
    int s, t, en1_seen, c0;
    int e0, e1, e2, eo, ef, ec, rd0, rd1, rd2;
    logic [2:0] rnv;

    vecs[0] = '{0, 0, 0, 3'b000, 10, 33, 66, 119, -1, 0};
    vecs[1] = '{5, 10, 2, 3'b000, 10, 38, 81, 136, -1, 0};
    vecs[2] = '{0, 0, 0, 3'b010, 10, 33, -1, -1, 73, 1};
    vecs[3] = '{0, 0, 0, 3'b001, 10, -1, -1, -1, 50, 0};
    vecs[4] = '{3, 4, 0, 3'b100, 10, 36, 73, -1, 113, 2};
    vecs[5] = '{30, 0, 34, 3'b000, 10, 63, 96, 183, -1, 0};

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_en", int'(en_out), 0);
    chk("rst_brst", int'(board_rst_n), 0);
    chk("rst_ok", int'(power_ok), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_fch", int'(fault_ch), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven scenarios.
    for (int v = 0; v < 6; v++) begin
      do_scn($sformatf("tab%0d", v), vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].nv,
             vecs[v].e_en0, vecs[v].e_en1, vecs[v].e_en2, vecs[v].e_ok,
             vecs[v].e_flt, vecs[v].e_fch);
    end

    // Abort in UP_DLY ch1, re-request during DOWN, abort in UP_PG ch0, then abort in UP_DLY ch0.
    en1_seen = 0;
    pwr_req = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 101; k++) begin
      @(negedge clk);
      t = cyc - s;
      pg = en_out;
      if (en_out[1]) en1_seen = 1;
      if (t == 20) begin chk("abort_en_pre", int'(en_out), 1); pwr_req = 1'b0; end
      if (t == 30) pwr_req = 1'b1;
      if (t == 40) chk("abort_en_40", int'(en_out), 1);
      if (t == 41) chk("abort_en_41", int'(en_out), 0);
      if (t == 51) chk("rereq_en_51", int'(en_out), 0);
      if (t == 52) chk("rereq_en_52", int'(en_out), 1);
      if (t == 53) pwr_req = 1'b0;
      if (t == 73) chk("pgabort_en_73", int'(en_out), 1);
      if (t == 74) chk("pgabort_en_74", int'(en_out), 0);
      if (t == 80) pwr_req = 1'b1;
      if (t == 85) pwr_req = 1'b0;
      if (t == 91) chk("dly0abort_en_91", int'(en_out), 0);
      if (t == 100) chk("dly0abort_en_100", int'(en_out), 0);
    end
    chk("abort_en1_never", en1_seen, 0);
    pg = '0;
    $display("abort: en1_seen=%0d", en1_seen);
    @(negedge clk);

    // Asynchronous reset while ON, then restart with pwr_req held high.
    run_scn(0, 0, 0, 3'b000, e0, e1, e2, eo, ef, ec, rd0, rd1);
    chk("pre_rst_ok", eo, 119);
    #2 reset_n = 1'b0;
    #1;
    chk("async_en", int'(en_out), 0);
    chk("async_brst", int'(board_rst_n), 0);
    chk("async_ok", int'(power_ok), 0);
    chk("async_fault", int'(fault), 0);
    pg = '0;
    @(negedge clk);
    reset_n = 1'b1;
    do_scn("after_rst", 0, 0, 0, 3'b000, 10, 33, 66, 119, -1, 0);

    // PG drop while ON.
    run_scn(0, 0, 0, 3'b000, e0, e1, e2, eo, ef, ec, rd0, rd1);
    chk("mon_pre_ok", eo, 119);
    pg[2] = 1'b0;
    c0 = cyc;
    repeat (2) @(negedge clk);
    chk("mon_fault_2", int'(fault), 0);
    @(negedge clk);
`ifdef PWRSEQ_PG_MONITOR_EN
    chk("mon_fault_3", int'(fault), 1);
    chk("mon_fch", int'(fault_ch), 2);
    chk("mon_en", int'(en_out), 0);
    $display("mon: fault=%0d ch=%0d at +%0d", fault, fault_ch, cyc - c0);
    clear_fault("mon", 2);
`else
    chk("mon_fault_3", int'(fault), 0);
    chk("mon_ok_3", int'(power_ok), 1);
    chk("mon_en_3", int'(en_out), 7);
    repeat (10) @(negedge clk);
    chk("mon_ok_13", int'(power_ok), 1);
    $display("mon: no response at +%0d", cyc - c0);
    pg[2] = 1'b1;
    power_down("mon");
`endif

    // Randomised scenarios against the timing model.
    for (int i = 0; i < 8; i++) begin
      rd0 = $urandom_range(0, 34);
      rd1 = $urandom_range(0, 34);
      rd2 = $urandom_range(0, 34);
      rnv = 3'b000;
      if ($urandom_range(0, 1) == 1) rnv[$urandom_range(0, 2)] = 1'b1;
      model(rd0, rd1, rd2, rnv, e0, e1, e2, eo, ef, ec);
      do_scn($sformatf("rnd%0d", i), rd0, rd1, rd2, rnv, e0, e1, e2, eo, ef, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwr_seq_multi.md
Name: pwr_seq_multi

Overview:
- Parametrised N-channel power-rail sequencer; successor to the single-delay power-up timer.
- Enables rails in ascending order with per-channel delays and checks each rail's power-good (PG) with a timeout.
- Releases a board reset after a hold time, powers down in reverse order when the request is withdrawn, and latches a fault on PG timeout.
- Sits between the board-level power request and the regulator enable pins and downstream reset.

Parameters:
- C_CLK_FREQ, 100_000, clk frequency in kHz (clocks per millisecond).
- N_CH, 4, number of rails (1..16).
- C_UP_DLY_MS, {8'd10,8'd10,8'd10,8'd10}, packed N_CH×8 bits; byte i = ms delay before enabling rail i (byte 0 = LSB).
- C_PG_TO_MS, 50, ms allowed for pg[i] to assert after en_out[i] (1..255).
- C_RST_HOLD_MS, 5, ms from last PG good to board reset release (0..255).
- C_DN_DLY_MS, 2, ms spacing between rail disables during power-down (0..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pwr_req  in  1  level; 1 = power up, 0 = power down.
- pg  in  N_CH  rail power-good, asynchronous, two-flop synchronised internally.
- fault_clr  in  1  single-cycle pulse, clears a latched fault.
- en_out  out  N_CH  rail enables, registered.
- board_rst_n  out  1  downstream reset, active-low, registered.
- power_ok  out  1  1 only in ON state.
- fault  out  1  latched PG-timeout fault.
- fault_ch  out  max(1,clog2(N_CH))  index of the failing rail.

Behaviour:
- Reset (reset_n=0, async): en_out=0, board_rst_n=0, power_ok=0, fault=0, fault_ch=0, state=IDLE, timers cleared, PG synchronisers cleared.
- Timer: a prescaler counts 0..C_CLK_FREQ-1 and an 8-bit ms counter increments on wrap. Both clear on every state entry and every ch change. A timed state with delay D exits after max(1, D×C_CLK_FREQ) clocks in the state.
- Checks: ms-counter width and per-byte values are checked at elaboration.
- States:
  - IDLE: outputs low. If pwr_req=1 and fault=0, go to UP_DLY with ch=0.
  - UP_DLY: wait C_UP_DLY_MS[ch]. At expiry set en_out[ch]=1 and go to UP_PG.
  - UP_PG: if pg_sync[ch]=1 and ch<N_CH-1, set ch++ and go to UP_DLY. If pg_sync[ch]=1 and ch=N_CH-1, go to RST_HOLD. If C_PG_TO_MS expires first, go to FAULT with fault_ch=ch. PG-assert-to-advance latency is 3 clocks (2 synchroniser stages + 1 state register).
  - RST_HOLD: wait C_RST_HOLD_MS. At expiry set board_rst_n=1, power_ok=1, and go to ON.
  - ON: hold. If pwr_req=0, set board_rst_n=0 and power_ok=0 on the same edge, then go to DOWN with ch=N_CH-1.
  - DOWN: wait C_DN_DLY_MS. At expiry clear en_out[ch]. If ch=0 go to IDLE, else ch--.
  - FAULT: en_out cleared to 0 in the entry cycle (all rails at once), board_rst_n=0, fault=1. Exit to IDLE only when fault_clr=1 and pwr_req=0 in the same cycle; this clears fault and fault_ch.
- pwr_req=0 during UP_DLY/UP_PG/RST_HOLD: the lower ranks are powered down in reverse order.
  - UP_PG or RST_HOLD: enter DOWN with the current ch.
  - UP_DLY with ch>0: enter DOWN with ch-1.
  - UP_DLY with ch=0: go straight to IDLE.
- pwr_req returning to 1 during DOWN: ignored until IDLE is reached.
- fault_clr outside FAULT: ignored.
- PG dropping after its rail has advanced: ignored unless PWRSEQ_PG_MONITOR_EN is defined.

Optional Feature:
- Macro: PWRSEQ_PG_MONITOR_EN.
- Defined: in RST_HOLD and ON, any pg_sync[i]=0 with en_out[i]=1 forces FAULT next edge, with fault_ch = lowest such i. PG-drop-to-fault latency is 3 clocks.
- Undefined: PG is checked only in UP_PG; the monitor logic is absent.

Test Plan:
- Common config: C_CLK_FREQ=10, N_CH=3, C_UP_DLY_MS=24'h030201, C_PG_TO_MS=4, C_RST_HOLD_MS=5, C_DN_DLY_MS=2.
- Reset: drive reset_n=0 mid-ON -> all outputs 0 immediately (asynchronous), no clock needed; after release, with pwr_req=1, the sequence restarts from ch0.
- Nominal power-up, pg = en_out mirrored: en_out[0] 10 clks after UP_DLY entry; en_out[1] 3+20 clks later; en_out[2] 3+30 clks after that; board_rst_n and power_ok high 3+50 clks after en_out[2].
- Power-down from ON: pwr_req=0 -> board_rst_n=0 on the next edge; en_out[2] clears 20 clks later, then en_out[1] after 20, en_out[0] after 20; then IDLE.
- PG timeout: pg[1] held 0 -> 40 clks after en_out[1] rises, fault=1, fault_ch=1, en_out=000. Pulsing fault_clr with pwr_req=1 -> no exit. Pulsing fault_clr with pwr_req=0 -> IDLE, fault=0.
- Abort during UP_DLY ch=1 (en_out=001): pwr_req=0 -> en_out[0] clears after 20 clks, then IDLE; rail 1 is never enabled.
- With PWRSEQ_PG_MONITOR_EN: in ON, drop pg[2] -> fault=1, fault_ch=2, en_out=000 3 clks later. Without the macro -> no response.
